// File: rtl/writeback_unit.sv
// writeback_unit: merges single-cycle ALU results and buffered load returns
// into one registered register-file write per cycle, and tracks outstanding
// loads per destination register for RAW-hazard stalling in decode.
// Optional feature macro: WB_LOAD_BYPASS_EN -- when defined, a load arriving
// at an idle unit (FIFO empty, no ALU write) goes straight to the output
// register instead of through the load FIFO.
module writeback_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_we,
    input  logic [3:0]  alu_addr,
    input  logic [7:0]  alu_data,
    output logic        alu_stall,
    input  logic        ld_issue,
    input  logic [3:0]  ld_issue_addr,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_addr,
    input  logic [7:0]  ld_data,
    output logic        rf_write_enable,
    output logic [3:0]  rf_write_addr,
    output logic [7:0]  rf_write_data,
    output logic [15:0] busy_mask,
    output logic [3:0]  fifo_count,
    output logic        err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // FIFO entry: {destination register, load data}
    typedef logic [11:0] entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]         count_q, count_d;
    logic [15:0]        busy_q, busy_d;
    logic               err_q, err_d;
    logic               we_q, we_d;
    logic [3:0]         waddr_q, waddr_d;
    logic [7:0]         wdata_q, wdata_d;

    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               bypass;
    logic               ld_write;
    entry_t             head;

    assign full  = (count_q == 4'(FIFO_DEPTH));
    assign empty = (count_q == 4'd0);
    assign head  = mem_q[rd_ptr_q];

    // Output-register source selection: full FIFO drains first, then ALU,
    // then any buffered load, then (optionally) a bypassed fresh load.
    always_comb begin
        pop      = 1'b0;
        bypass   = 1'b0;
        ld_write = 1'b0;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (full) begin
            pop      = 1'b1;
            ld_write = 1'b1;
            we_d     = 1'b1;
            waddr_d  = head[11:8];
            wdata_d  = head[7:0];
        end else if (alu_we) begin
            we_d     = 1'b1;
            waddr_d  = alu_addr;
            wdata_d  = alu_data;
        end else if (!empty) begin
            pop      = 1'b1;
            ld_write = 1'b1;
            we_d     = 1'b1;
            waddr_d  = head[11:8];
            wdata_d  = head[7:0];
`ifdef WB_LOAD_BYPASS_EN
        end else if (ld_valid) begin
            bypass   = 1'b1;
            ld_write = 1'b1;
            we_d     = 1'b1;
            waddr_d  = ld_addr;
            wdata_d  = ld_data;
`endif
        end
    end

    // FIFO push/pop bookkeeping; ld_ready is derived from the pre-edge count
    always_comb begin
        push     = ld_valid && !full && !bypass;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + {3'b000, push} - {3'b000, pop};
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ld_addr, ld_data};
        end
    end

    // Scoreboard update (issue beats retire on the same bit) and sticky error
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (alu_we && full) begin
            err_d = 1'b1;
        end
        if (ld_write) begin
            if (!busy_q[waddr_d]) begin
                err_d = 1'b1;
            end
            busy_d[waddr_d] = 1'b0;
        end
        if (ld_issue) begin
            busy_d[ld_issue_addr] = 1'b1;
        end
    end

    // Control and output registers, cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage; contents are meaningless once pointers/count are reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign alu_stall       = full;
    assign ld_ready        = !full;
    assign rf_write_enable = we_q;
    assign rf_write_addr   = waddr_q;
    assign rf_write_data   = wdata_q;
    assign busy_mask       = busy_q;
    assign fifo_count      = count_q;
    assign err             = err_q;

endmodule
